// File: rtl/sort4_if.sv
// Handshake and data bundle between a requester and the 4-element sorter.
interface sort4_if;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic [2:0]  swap_count;

    modport master (
        output start, data_in,
        input  busy, done, data_out, swap_count
    );

    modport slave (
        input  start, data_in,
        output busy, done, data_out, swap_count
    );
endinterface

// File: rtl/sort4_ctrl.sv
// Four-element, 4-bit ascending sorter. A fixed six-step bubble network is
// walked one compare-and-swap per cycle through a single shared comparator.

// 4-bit unsigned less-than comparator.
module lt4 (
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       lt
);
    assign lt = (data_a < data_b);
endmodule

module sort4_ctrl (
    input  logic   clk,
    input  logic   rst,
    sort4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      step;
    logic [3:0][3:0] work;
    logic [3:0][3:0] work_swp;
    logic [2:0]      acc;
    logic [2:0]      acc_nxt;
    logic [1:0]      idx;
    logic [3:0]      elem_lo;
    logic [3:0]      elem_hi;
    logic            lt;
    logic            busy_c;
    logic            done_c;
    logic [15:0]     data_out_q;
    logic [2:0]      swap_count_q;

    // Map the step number onto the lower index of the pair being compared.
    always_comb begin
        idx = 2'd0;
        case (step)
            3'd0:    idx = 2'd0;
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd3:    idx = 2'd0;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    assign elem_lo = work[idx];
    assign elem_hi = work[idx + 2'd1];

    // Strict less-than on (upper, lower): equal entries stay put, keeping the sort stable.
    lt4 u_lt4 (
        .data_a (elem_hi),
        .data_b (elem_lo),
        .lt     (lt)
    );

    // Candidate work register and swap tally after the current compare step.
    always_comb begin
        work_swp = work;
        if (lt) begin
            work_swp[idx]         = elem_hi;
            work_swp[idx + 2'd1]  = elem_lo;
        end
        acc_nxt = acc + {2'b00, lt};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = SORT;
            end
            SORT: begin
                busy_c = 1'b1;
                if (step == 3'd5) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Work register, step counter, swap tally and published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work         <= '0;
            step         <= 3'd0;
            acc          <= 3'd0;
            data_out_q   <= 16'h0000;
            swap_count_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work <= bus.data_in;
                        step <= 3'd0;
                        acc  <= 3'd0;
                    end
                end
                SORT: begin
                    work <= work_swp;
                    acc  <= acc_nxt;
                    step <= step + 3'd1;
                    if (step == 3'd5) begin
                        data_out_q   <= work_swp;
                        swap_count_q <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.data_out   = data_out_q;
    assign bus.swap_count = swap_count_q;
endmodule
